multi_dir_signal_ctrl: RTL and testbench

//  Parametrised N-direction intersection controller; successor to the fixed 2-road, 3-state controller.
//  - Cycles GREEN -> YELLOW -> ALL_RED round-robin over NUM_DIR approaches.
//  - Per-phase durations are counted in ticks of an external strobe.
//  - Optional demand-based skipping of approaches.
//  - Directed emergency preemption of one chosen approach, with a safe yellow/all-red exit from the current green.

---
 rtl/traffic_pkg.sv | 18 +
 rtl/multi_dir_signal_ctrl_if.sv | 28 ++
 rtl/phase_timer.sv | 34 +++
 rtl/multi_dir_signal_ctrl.sv | 177 +++++++++++++++++
 tb/tb_multi_dir_signal_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// Shared phase encoding and duration range check for the intersection controller.
package traffic_pkg;

   localparam int PHASE_W = 2;

   typedef enum logic [PHASE_W-1:0] {
      PH_ALLRED = 2'd0,
      PH_GREEN  = 2'd1,
      PH_YELLOW = 2'd2,
      PH_EMERG  = 2'd3
   } phase_e;

   // A duration must be loadable as duration-1 into a cnt_w-bit timer.
   function automatic bit dur_ok(input int ticks, input int cnt_w);
      return (ticks >= 1) && (ticks <= (2 ** cnt_w) - 1);
   endfunction

endpackage

// File: rtl/multi_dir_signal_ctrl_if.sv
// Controller bus: tick strobe and requests in, lamp drives and status out.
interface multi_dir_signal_ctrl_if
   import traffic_pkg::*;
#(
   parameter int NUM_DIR = 4,
   parameter int IDX_W   = $clog2(NUM_DIR)
) ();
   logic               tick;
   logic [NUM_DIR-1:0] demand;
   logic               emergency;
   logic [IDX_W-1:0]   emerg_dir;
   logic [NUM_DIR-1:0] red;
   logic [NUM_DIR-1:0] yellow;
   logic [NUM_DIR-1:0] green;
   logic [IDX_W-1:0]   cur_dir;
   logic [PHASE_W-1:0] phase;
   logic               emerg_active;

   modport master (
      output tick, demand, emergency, emerg_dir,
      input  red, yellow, green, cur_dir, phase, emerg_active
   );

   modport slave (
      input  tick, demand, emergency, emerg_dir,
      output red, yellow, green, cur_dir, phase, emerg_active
   );
endinterface

// File: rtl/phase_timer.sv
// Loadable down-counter advanced by a tick strobe; done while the count sits at zero.
module phase_timer #(
   parameter int CNT_W   = 8,
   parameter int RST_VAL = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             done
);
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (tick && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= CNT_W'(RST_VAL);
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == '0);
endmodule

// File: rtl/multi_dir_signal_ctrl.sv
// N-approach round-robin signal controller with demand skipping and directed
// emergency preemption; lamps are registered alongside the phase.
module multi_dir_signal_ctrl
   import traffic_pkg::*;
#(
   parameter int NUM_DIR      = 4,
   parameter int CNT_W        = 8,
   parameter int GREEN_TICKS  = 20,
   parameter int YELLOW_TICKS = 4,
   parameter int ALLRED_TICKS = 2,
   parameter int SKIP_EN      = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   multi_dir_signal_ctrl_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_DIR);
   localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_TICKS - 1);
   localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_TICKS - 1);
   localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_TICKS - 1);
   localparam logic [IDX_W-1:0] LAST_DIR  = IDX_W'(NUM_DIR - 1);
   localparam logic [IDX_W:0]   NUM_DIR_W = (IDX_W + 1)'(NUM_DIR);

   if (NUM_DIR < 2 || NUM_DIR > 16) begin : g_chk_dir
      $error("NUM_DIR must be 2..16");
   end
   if (!dur_ok(GREEN_TICKS, CNT_W)) begin : g_chk_green
      $error("GREEN_TICKS out of range for CNT_W");
   end
   if (!dur_ok(YELLOW_TICKS, CNT_W)) begin : g_chk_yellow
      $error("YELLOW_TICKS out of range for CNT_W");
   end
   if (!dur_ok(ALLRED_TICKS, CNT_W)) begin : g_chk_allred
      $error("ALLRED_TICKS out of range for CNT_W");
   end

   phase_e             phase_q, phase_d;
   logic [IDX_W-1:0]   dir_q, dir_d;
   logic [NUM_DIR-1:0] red_q, red_d, yellow_q, yellow_d, green_q, green_d;
   logic [NUM_DIR-1:0] sel_d, dir_onehot;
   logic [IDX_W-1:0]   next_dir, hi_dir, lo_dir;
   logic               hi_found, lo_found;
   logic               timer_load, timer_done, expiry, valid_emerg, other_demand;
   logic [CNT_W-1:0]   timer_val;

   phase_timer #(
      .CNT_W   (CNT_W),
      .RST_VAL (ALLRED_TICKS - 1)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .tick     (bus.tick),
      .load     (timer_load),
      .load_val (timer_val),
      .done     (timer_done)
   );

   assign expiry       = bus.tick && timer_done;
   assign valid_emerg  = bus.emergency && ({1'b0, bus.emerg_dir} < NUM_DIR_W);
   assign dir_onehot   = NUM_DIR'(1) << dir_q;
   assign other_demand = |(bus.demand & ~dir_onehot);

   // Wrapped priority search: lowest requesting index above cur_dir, else lowest at or below it.
   always_comb begin
      hi_found = 1'b0;
      lo_found = 1'b0;
      hi_dir   = '0;
      lo_dir   = '0;
      for (int j = NUM_DIR - 1; j >= 0; j--) begin
         if (bus.demand[j]) begin
            if (j > int'(dir_q)) begin
               hi_found = 1'b1;
               hi_dir   = IDX_W'(j);
            end else begin
               lo_found = 1'b1;
               lo_dir   = IDX_W'(j);
            end
         end
      end
      if (SKIP_EN != 0 && hi_found) begin
         next_dir = hi_dir;
      end else if (SKIP_EN != 0 && lo_found) begin
         next_dir = lo_dir;
      end else begin
         next_dir = (dir_q == LAST_DIR) ? '0 : dir_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q  <= PH_ALLRED;
         dir_q    <= LAST_DIR;
         red_q    <= '1;
         yellow_q <= '0;
         green_q  <= '0;
      end else begin
         phase_q  <= phase_d;
         dir_q    <= dir_d;
         red_q    <= red_d;
         yellow_q <= yellow_d;
         green_q  <= green_d;
      end
   end

   always_comb begin
      phase_d    = phase_q;
      dir_d      = dir_q;
      timer_load = 1'b0;
      timer_val  = GREEN_LD;
      case (phase_q)
         PH_ALLRED: begin
            if (expiry) begin
               timer_load = 1'b1;
               if (valid_emerg) begin
                  phase_d = PH_EMERG;
                  dir_d   = bus.emerg_dir;
               end else begin
                  phase_d = PH_GREEN;
                  dir_d   = next_dir;
               end
            end
         end
         PH_GREEN: begin
            // Preemption outranks a coincident green expiry.
            if (valid_emerg) begin
               timer_load = 1'b1;
               if (bus.emerg_dir == dir_q) begin
                  phase_d = PH_EMERG;
               end else begin
                  phase_d   = PH_YELLOW;
                  timer_val = YELLOW_LD;
               end
            end else if (expiry) begin
               timer_load = 1'b1;
               if (!(SKIP_EN != 0 && !other_demand)) begin
                  phase_d   = PH_YELLOW;
                  timer_val = YELLOW_LD;
               end
            end
         end
         PH_YELLOW: begin
            if (expiry) begin
               timer_load = 1'b1;
               phase_d    = PH_ALLRED;
               timer_val  = ALLRED_LD;
            end
         end
         PH_EMERG: begin
            if (!valid_emerg || (bus.emerg_dir != dir_q)) begin
               timer_load = 1'b1;
               phase_d    = PH_YELLOW;
               timer_val  = YELLOW_LD;
            end
         end
         default: begin
            phase_d = PH_ALLRED;
         end
      endcase
   end

   for (genvar gi = 0; gi < NUM_DIR; gi++) begin : g_sel
      assign sel_d[gi] = (dir_d == IDX_W'(gi));
   end

   always_comb begin
      green_d  = sel_d & {NUM_DIR{(phase_d == PH_GREEN) || (phase_d == PH_EMERG)}};
      yellow_d = sel_d & {NUM_DIR{phase_d == PH_YELLOW}};
      red_d    = ~(green_d | yellow_d);
   end

   assign bus.red          = red_q;
   assign bus.yellow       = yellow_q;
   assign bus.green        = green_q;
   assign bus.cur_dir      = dir_q;
   assign bus.phase        = phase_q;
   assign bus.emerg_active = (phase_q == PH_EMERG);
endmodule

// File: tb/tb_multi_dir_signal_ctrl.sv
// Checks a 4-way (skip on) and a 3-way (skip off) controller against a
// remaining-ticks model of the phase rules, plus directed lamp sequences.
module tb_multi_dir_signal_ctrl;
   localparam int G = 3;
   localparam int Y = 2;
   localparam int A = 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic       tick_v = 1'b1;
   logic [3:0] dem_v [2];
   logic       em_v  [2];
   logic [1:0] edir_v[2];

   multi_dir_signal_ctrl_if #(.NUM_DIR(4)) if4 ();
   multi_dir_signal_ctrl_if #(.NUM_DIR(3)) if3 ();

   assign if4.tick      = tick_v;
   assign if4.demand    = dem_v[0];
   assign if4.emergency = em_v[0];
   assign if4.emerg_dir = edir_v[0];
   assign if3.tick      = tick_v;
   assign if3.demand    = dem_v[1][2:0];
   assign if3.emergency = em_v[1];
   assign if3.emerg_dir = edir_v[1];

   multi_dir_signal_ctrl #(
      .NUM_DIR(4), .CNT_W(8), .GREEN_TICKS(G), .YELLOW_TICKS(Y),
      .ALLRED_TICKS(A), .SKIP_EN(1)
   ) dut4 (.clk(clk), .reset(reset), .bus(if4));

   multi_dir_signal_ctrl #(
      .NUM_DIR(3), .CNT_W(8), .GREEN_TICKS(G), .YELLOW_TICKS(Y),
      .ALLRED_TICKS(A), .SKIP_EN(0)
   ) dut3 (.clk(clk), .reset(reset), .bus(if3));

   int n_cmp = 0;
   int n_bad = 0;

   // Model: phase 0 all-red, 1 green, 2 yellow, 3 emergency; m_left = ticks still owed.
   int m_ph[2], m_dir[2], m_left[2];
   int nd[2]  = '{4, 3};
   bit skp[2] = '{1'b1, 1'b0};

   task automatic model_reset();
      for (int u = 0; u < 2; u++) begin
         m_ph[u] = 0; m_dir[u] = nd[u] - 1; m_left[u] = A;
      end
   endtask

   function automatic int pick(int u);
      for (int k = 1; k <= nd[u]; k++) begin
         int j = (m_dir[u] + k) % nd[u];
         if (skp[u] && dem_v[u][j]) return j;
      end
      return (m_dir[u] + 1) % nd[u];
   endfunction

   function automatic bit others_waiting(int u);
      for (int j = 0; j < nd[u]; j++)
         if (j != m_dir[u] && dem_v[u][j]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_step(int u);
      bit valid = em_v[u] && (int'(edir_v[u]) < nd[u]);
      bit ends  = tick_v && (m_left[u] == 1);
      case (m_ph[u])
         0: if (ends) begin
               if (valid) begin m_ph[u] = 3; m_dir[u] = int'(edir_v[u]); end
               else begin m_dir[u] = pick(u); m_ph[u] = 1; m_left[u] = G; end
            end else if (tick_v) m_left[u]--;
         1: if (valid) begin
               if (int'(edir_v[u]) == m_dir[u]) m_ph[u] = 3;
               else begin m_ph[u] = 2; m_left[u] = Y; end
            end else if (ends) begin
               if (skp[u] && !others_waiting(u)) m_left[u] = G;
               else begin m_ph[u] = 2; m_left[u] = Y; end
            end else if (tick_v) m_left[u]--;
         2: if (ends) begin m_ph[u] = 0; m_left[u] = A; end
            else if (tick_v) m_left[u]--;
         default: if (!valid || int'(edir_v[u]) != m_dir[u]) begin
               m_ph[u] = 2; m_left[u] = Y;
            end
      endcase
   endtask

   // {phase, cur_dir, emerg_active, red, yellow, green}
   function automatic logic [16:0] exp_v(int u);
      logic [3:0] r = '0, yl = '0, g = '0;
      for (int i = 0; i < nd[u]; i++) begin
         if (i == m_dir[u] && (m_ph[u] == 1 || m_ph[u] == 3)) g[i] = 1'b1;
         else if (i == m_dir[u] && m_ph[u] == 2) yl[i] = 1'b1;
         else r[i] = 1'b1;
      end
      return {2'(m_ph[u]), 2'(m_dir[u]), (m_ph[u] == 3), r, yl, g};
   endfunction

   function automatic logic [16:0] act_v(int u);
      if (u == 0)
         return {if4.phase, if4.cur_dir, if4.emerg_active, if4.red, if4.yellow, if4.green};
      return {if3.phase, if3.cur_dir, if3.emerg_active,
              1'b0, if3.red, 1'b0, if3.yellow, 1'b0, if3.green};
   endfunction

   function automatic bit lamps_ok(int u);
      logic [16:0] a = act_v(u);
      int lit_dirs = 0;
      for (int i = 0; i < nd[u]; i++) begin
         if ((int'(a[8+i]) + int'(a[4+i]) + int'(a[i])) != 1) return 1'b0;
         if (!a[8+i]) lit_dirs++;
      end
      return lit_dirs <= 1;
   endfunction

   task automatic step();
      @(posedge clk);
      if (reset) model_reset();
      else for (int u = 0; u < 2; u++) model_step(u);
      #1;
   endtask

   task automatic restart();
      reset = 1'b1;
      #1;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic set_quiet();
      tick_v = 1'b1;
      for (int u = 0; u < 2; u++) begin
         dem_v[u] = 4'b1111; em_v[u] = 1'b0; edir_v[u] = 2'd0;
      end
   endtask

   task automatic test_reset();
      set_quiet();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      for (int u = 0; u < 2; u++) begin
         n_cmp++;
         if (act_v(u) !== exp_v(u)) begin
            n_bad++;
            $display("FAIL reset u%0d: got %h want %h", u, act_v(u), exp_v(u));
         end
      end
      n_cmp++;
      if ({if4.red, if4.yellow, if4.green, if4.cur_dir} !== {4'hF, 4'h0, 4'h0, 2'd3}) begin
         n_bad++;
         $display("FAIL reset_lamps: got r%b y%b g%b d%0d want r1111 y0000 g0000 d3",
                  if4.red, if4.yellow, if4.green, if4.cur_dir);
      end
      $display("test_reset done");
   endtask

   task automatic test_sequence();
      int g_tab[7] = '{1, 1, 1, 0, 0, 0, 2};
      int y_tab[7] = '{0, 0, 0, 1, 1, 0, 0};
      set_quiet();
      restart();
      for (int c = 0; c < 7; c++) begin
         step();
         n_cmp++;
         if ({if4.green, if4.yellow} !== {4'(g_tab[c]), 4'(y_tab[c])}) begin
            n_bad++;
            $display("FAIL seq c%0d: got g%b y%b want g%b y%b", c, if4.green, if4.yellow,
                     4'(g_tab[c]), 4'(y_tab[c]));
         end
         for (int u = 0; u < 2; u++) begin
            n_cmp++;
            if (act_v(u) !== exp_v(u)) begin
               n_bad++;
               $display("FAIL seq_model u%0d c%0d: got %h want %h", u, c, act_v(u), exp_v(u));
            end
         end
      end
      $display("test_sequence done");
   endtask

   task automatic test_emerg_other();
      // 13 cycles: yellow d0 x2, all-red, then emergency green on d2 held 10
      logic [11:0] hold_tab[13];
      logic [11:0] exit_tab[4];
      for (int c = 0; c < 13; c++)
         hold_tab[c] = (c < 2) ? 12'hE_1_0 : (c == 2) ? 12'hF_0_0 : 12'hB_0_4;
      exit_tab[0] = 12'hB_4_0; exit_tab[1] = 12'hB_4_0;
      exit_tab[2] = 12'hF_0_0; exit_tab[3] = 12'h7_0_8;
      set_quiet();
      restart();
      step();
      em_v[0] = 1'b1; edir_v[0] = 2'd2;
      for (int c = 0; c < 17; c++) begin
         if (c == 13) em_v[0] = 1'b0;
         step();
         n_cmp++;
         if (c < 13 ? ({if4.red, if4.yellow, if4.green} !== hold_tab[c])
                    : ({if4.red, if4.yellow, if4.green} !== exit_tab[c-13])) begin
            n_bad++;
            $display("FAIL emerg_other c%0d: got rygb %h want %h", c,
                     {if4.red, if4.yellow, if4.green}, c < 13 ? hold_tab[c] : exit_tab[c-13]);
         end
         if (c >= 3 && c < 13) begin
            n_cmp++;
            if ({if4.phase, if4.emerg_active} !== 3'b111) begin
               n_bad++;
               $display("FAIL emerg_phase c%0d: got ph%0d ea%b want ph3 ea1", c, if4.phase, if4.emerg_active);
            end
         end
         n_cmp++;
         if (act_v(0) !== exp_v(0)) begin
            n_bad++;
            $display("FAIL emerg_other_model c%0d: got %h want %h", c, act_v(0), exp_v(0));
         end
      end
      $display("test_emerg_other done");
   endtask

   task automatic test_emerg_same();
      set_quiet();
      restart();
      repeat (7) step();
      em_v[0] = 1'b1; edir_v[0] = 2'd1;
      for (int c = 0; c < 6; c++) begin
         step();
         n_cmp++;
         if ({if4.phase, if4.green, if4.yellow} !== {2'd3, 4'b0010, 4'b0000}) begin
            n_bad++;
            $display("FAIL emerg_same c%0d: got ph%0d g%b y%b want ph3 g0010 y0000",
                     c, if4.phase, if4.green, if4.yellow);
         end
         n_cmp++;
         if (act_v(0) !== exp_v(0)) begin
            n_bad++;
            $display("FAIL emerg_same_model c%0d: got %h want %h", c, act_v(0), exp_v(0));
         end
      end
      em_v[0] = 1'b0;
      $display("test_emerg_same done");
   endtask

   task automatic test_skip();
      set_quiet();
      restart();
      step();
      dem_v[0] = 4'b0100;
      repeat (6) step();
      n_cmp++;
      if (if4.green !== 4'b0100) begin
         n_bad++;
         $display("FAIL skip_select: got g%b want g0100", if4.green);
      end
      dem_v[0] = 4'b0000;
      for (int c = 0; c < 10; c++) begin
         step();
         n_cmp++;
         if ({if4.green, if4.phase} !== {4'b0100, 2'd1}) begin
            n_bad++;
            $display("FAIL skip_extend c%0d: got g%b ph%0d want g0100 ph1", c, if4.green, if4.phase);
         end
         n_cmp++;
         if (act_v(0) !== exp_v(0)) begin
            n_bad++;
            $display("FAIL skip_model c%0d: got %h want %h", c, act_v(0), exp_v(0));
         end
      end
      $display("test_skip done");
   endtask

   task automatic test_slow_tick();
      int g_cnt = 0, y_cnt = 0;
      set_quiet();
      restart();
      for (int c = 0; c < 41; c++) begin
         tick_v = (c % 4 == 3);
         step();
         if (if4.green == 4'b0001) g_cnt++;
         if (if4.yellow == 4'b0001) y_cnt++;
         n_cmp++;
         if (act_v(0) !== exp_v(0)) begin
            n_bad++;
            $display("FAIL slow_model c%0d: got %h want %h", c, act_v(0), exp_v(0));
         end
      end
      n_cmp++;
      if (g_cnt != 4 * G || y_cnt != 4 * Y) begin
         n_bad++;
         $display("FAIL slow_len: got green %0d yellow %0d want %0d %0d", g_cnt, y_cnt, 4 * G, 4 * Y);
      end
      n_cmp++;
      if (if4.yellow !== 4'b0010) begin
         n_bad++;
         $display("FAIL slow_midyellow: got y%b want y0010", if4.yellow);
      end
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      n_cmp++;
      if ({if4.red, if4.yellow, if4.green, if4.phase} !== {4'hF, 4'h0, 4'h0, 2'd0}) begin
         n_bad++;
         $display("FAIL async_reset: got r%b y%b g%b ph%0d want r1111 y0000 g0000 ph0",
                  if4.red, if4.yellow, if4.green, if4.phase);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      tick_v = 1'b1;
      for (int c = 0; c < 7; c++) begin
         step();
         n_cmp++;
         if (act_v(0) !== exp_v(0)) begin
            n_bad++;
            $display("FAIL restart_model c%0d: got %h want %h", c, act_v(0), exp_v(0));
         end
      end
      $display("test_slow_tick done");
   endtask

   task automatic test_invalid_emerg();
      set_quiet();
      restart();
      em_v[1] = 1'b1; edir_v[1] = 2'd3;
      for (int c = 0; c < 60; c++) begin
         dem_v[1] = 4'($urandom_range(0, 7));
         tick_v   = ($urandom_range(0, 3) != 0);
         step();
         n_cmp++;
         if (if3.emerg_active !== 1'b0 || !lamps_ok(1)) begin
            n_bad++;
            $display("FAIL invalid_emerg c%0d: got ea%b lamps_ok%b want ea0 lamps_ok1",
                     c, if3.emerg_active, lamps_ok(1));
         end
         n_cmp++;
         if (act_v(1) !== exp_v(1)) begin
            n_bad++;
            $display("FAIL invalid_emerg_model c%0d: got %h want %h", c, act_v(1), exp_v(1));
         end
      end
      $display("test_invalid_emerg done");
   endtask

   task automatic test_random();
      set_quiet();
      restart();
      for (int c = 0; c < 1500; c++) begin
         tick_v = ($urandom_range(0, 3) != 0);
         for (int u = 0; u < 2; u++) begin
            if ($urandom_range(0, 5) == 0) dem_v[u] = 4'($urandom);
            if ($urandom_range(0, 24) == 0) em_v[u] = ~em_v[u];
            if ($urandom_range(0, 19) == 0) edir_v[u] = 2'($urandom);
         end
         step();
         for (int u = 0; u < 2; u++) begin
            n_cmp++;
            if (act_v(u) !== exp_v(u) || !lamps_ok(u)) begin
               n_bad++;
               $display("FAIL random u%0d c%0d: got %h want %h lamps_ok%b",
                        u, c, act_v(u), exp_v(u), lamps_ok(u));
            end
         end
      end
      $display("test_random done");
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_emerg_other();
      test_emerg_same();
      test_skip();
      test_slow_tick();
      test_invalid_emerg();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
